// File: rtl/cache_flush_ctrl.sv
// Flush sequencer: walks every set/way, writes back dirty lines and clears their dirty bits.
// Build option CACHE_FLUSH_INVALIDATE_EN additionally invalidates every line while advancing.
module cache_flush_ctrl #(
  parameter int NUMWAYS  = 4,
  parameter int NUMLINES = 128,
  parameter int SETLEN   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushReq,
  input  logic [NUMWAYS-1:0] DirtyWay,
  input  logic               WriteBackAck,
  output logic [SETLEN-1:0]  FlushAdr,
  output logic [NUMWAYS-1:0] FlushWay,
  output logic               FlushAdrSel,
  output logic               WriteBackReq,
  output logic               ClearDirty,
  output logic               ClearValid,
  output logic               Busy,
  output logic               FlushDone
);

  localparam int WAYLEN = $clog2(NUMWAYS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CHECK   = 3'd2,
    WB      = 3'd3,
    CLEAN   = 3'd4,
    ADVANCE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t             state_r;
  logic [SETLEN-1:0]  set_cnt_r;
  logic [WAYLEN-1:0]  way_cnt_r;
  logic [NUMWAYS-1:0] way_oh_r;
  logic               busy_r;
  logic               wb_req_r;
  logic               clr_dirty_r;
  logic               done_r;
  logic               last_way_s;
  logic               last_set_s;
  logic               line_dirty_s;

  assign last_way_s   = (way_cnt_r == WAYLEN'(NUMWAYS - 1));
  assign last_set_s   = (set_cnt_r == SETLEN'(NUMLINES - 1));
  assign line_dirty_s = DirtyWay[way_cnt_r];

  assign FlushAdr     = set_cnt_r;
  assign FlushWay     = way_oh_r;
  assign Busy         = busy_r;
  assign FlushAdrSel  = busy_r;
  assign WriteBackReq = wb_req_r;
  assign ClearDirty   = clr_dirty_r;
  assign FlushDone    = done_r;

  // Walk FSM; outputs are registered alongside the transition that enters each state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      set_cnt_r   <= '0;
      way_cnt_r   <= '0;
      way_oh_r    <= NUMWAYS'(1);
      busy_r      <= 1'b0;
      wb_req_r    <= 1'b0;
      clr_dirty_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r      <= 1'b1;
      wb_req_r    <= 1'b0;
      clr_dirty_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (FlushReq) begin
            state_r   <= READ;
            set_cnt_r <= '0;
            way_cnt_r <= '0;
            way_oh_r  <= NUMWAYS'(1);
          end else begin
            busy_r <= 1'b0;
          end
        end
        READ: begin
          state_r <= CHECK;
        end
        CHECK: begin
          if (line_dirty_s) begin
            state_r  <= WB;
            wb_req_r <= 1'b1;
          end else begin
            state_r <= ADVANCE;
          end
        end
        WB: begin
          if (WriteBackAck) begin
            state_r     <= CLEAN;
            clr_dirty_r <= 1'b1;
          end else begin
            wb_req_r <= 1'b1;
          end
        end
        CLEAN: begin
          state_r <= ADVANCE;
        end
        ADVANCE: begin
          if (!last_way_s) begin
            state_r   <= READ;
            way_cnt_r <= way_cnt_r + WAYLEN'(1);
            way_oh_r  <= {way_oh_r[NUMWAYS-2:0], 1'b0};
          end else begin
            way_cnt_r <= '0;
            way_oh_r  <= NUMWAYS'(1);
            if (!last_set_s) begin
              state_r   <= READ;
              set_cnt_r <= set_cnt_r + SETLEN'(1);
            end else begin
              state_r   <= DONE;
              set_cnt_r <= '0;
              done_r    <= 1'b1;
            end
          end
        end
        DONE: begin
          // A request still held at completion chains straight into a new walk.
          if (FlushReq) begin
            state_r <= READ;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_FLUSH_INVALIDATE_EN
  logic clr_valid_r;

  // Pulse on entry to ADVANCE so the line still shown during ADVANCE is invalidated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_valid_r <= 1'b0;
    end else begin
      clr_valid_r <= ((state_r == CHECK) && !line_dirty_s) || (state_r == CLEAN);
    end
  end

  assign ClearValid = clr_valid_r;
`else
  assign ClearValid = 1'b0;
`endif

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Directed bench for cache_flush_ctrl in a 2-way x 4-set configuration.
module tb_cache_flush_ctrl;
  localparam int NW = 2;
  localparam int NL = 4;
  localparam int SL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          FlushReq = 1'b0;
  logic          WriteBackAck = 1'b0;
  logic [NW-1:0] DirtyWay;
  logic [SL-1:0] FlushAdr;
  logic [NW-1:0] FlushWay;
  logic          FlushAdrSel, WriteBackReq, ClearDirty, ClearValid, Busy, FlushDone;

  always #5 clk = ~clk;

  cache_flush_ctrl #(.NUMWAYS(NW), .NUMLINES(NL), .SETLEN(SL)) dut (
    .clk(clk), .reset(reset), .FlushReq(FlushReq), .DirtyWay(DirtyWay),
    .WriteBackAck(WriteBackAck), .FlushAdr(FlushAdr), .FlushWay(FlushWay),
    .FlushAdrSel(FlushAdrSel), .WriteBackReq(WriteBackReq), .ClearDirty(ClearDirty),
    .ClearValid(ClearValid), .Busy(Busy), .FlushDone(FlushDone)
  );

  // Dirty-bit array model: one-cycle read latency, cleared by ClearDirty.
  logic [NW*NL-1:0] dirty_mem, dirty_init;
  logic             load_mem = 1'b0;
  always @(posedge clk) begin
    if (load_mem) dirty_mem <= dirty_init;
    else if (ClearDirty) dirty_mem[int'(FlushAdr)*NW + int'(FlushWay[1])] <= 1'b0;
    DirtyWay <= dirty_mem[int'(FlushAdr)*NW +: NW];
  end

  // Bus model: ack after ack_delay full WB cycles, or permanently high.
  int   ack_delay = 0;
  logic ack_always = 1'b0;
  int   wb_cnt = 0;
  always @(negedge clk) begin
    if (WriteBackReq) wb_cnt = wb_cnt + 1;
    else wb_cnt = 0;
    WriteBackAck = ack_always || (WriteBackReq && (wb_cnt > ack_delay));
  end

  typedef struct {
    logic busy, done, wbreq, clrd, clrv, sel;
    logic [SL-1:0] adr;
    logic [NW-1:0] way;
  } smp_t;

  typedef struct {
    int cyc;
    logic busy, done, wbreq, clrd;
    logic [SL-1:0] adr;
    logic [NW-1:0] way;
  } vec_t;

  smp_t lg[0:63];
  vec_t vq[$];
  int   errs = 0, checks = 0;
  int   nb, nd, nw, nc, nv, sb, badcyc;
  logic [7:0] vmask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    dirty_init = v;
    load_mem = 1'b1;
    @(negedge clk);
    load_mem = 1'b0;
  endtask

  // Cycle 0 is the FlushReq cycle; FlushReq is also high on cycles hf..ht.
  task automatic run(input int ncyc, input int hf, input int ht);
    for (int n = 0; n <= ncyc; n++) begin
      @(negedge clk);
      FlushReq = (n == 0) || (n >= hf && n <= ht);
      #1;
      lg[n] = '{Busy, FlushDone, WriteBackReq, ClearDirty, ClearValid, FlushAdrSel, FlushAdr, FlushWay};
    end
    FlushReq = 1'b0;
  endtask

  task automatic apply_table(input string tag);
    foreach (vq[i]) begin
      chk($sformatf("%s c%0d busy/done/wbreq/clrd", tag, vq[i].cyc),
          {28'd0, lg[vq[i].cyc].busy, lg[vq[i].cyc].done, lg[vq[i].cyc].wbreq, lg[vq[i].cyc].clrd},
          {28'd0, vq[i].busy, vq[i].done, vq[i].wbreq, vq[i].clrd});
      chk($sformatf("%s c%0d adr/way", tag, vq[i].cyc),
          {28'd0, lg[vq[i].cyc].adr, lg[vq[i].cyc].way}, {28'd0, vq[i].adr, vq[i].way});
    end
    vq.delete();
  endtask

  task automatic tally(input int ncyc);
    nb = 0; nd = 0; nw = 0; nc = 0; nv = 0; sb = 0;
    for (int n = 0; n <= ncyc; n++) begin
      nb += int'(lg[n].busy);
      nd += int'(lg[n].done);
      nw += int'(lg[n].wbreq);
      nc += int'(lg[n].clrd);
      nv += int'(lg[n].clrv);
      if (lg[n].sel !== lg[n].busy) sb++;
      if (lg[n].wbreq && lg[n].clrd) sb++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Asynchronous reset, also held across a clock edge with FlushReq high.
    #2 reset = 1'b0;
    FlushReq = 1'b1;
    #1;
    chk("reset ctrl", {26'd0, Busy, FlushDone, WriteBackReq, ClearDirty, ClearValid, FlushAdrSel}, 32'd0);
    chk("reset adr/way", {28'd0, FlushAdr, FlushWay}, {28'd0, 2'd0, 2'b01});
    @(posedge clk); #1;
    chk("reset holds busy", {31'd0, Busy}, 32'd0);
    FlushReq = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // All lines clean.
    load(8'h00);
    run(27, 99, 0);
    vq.push_back('{0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01});
    vq.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01});
    vq.push_back('{24, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'b10});
    vq.push_back('{25, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'b01});
    vq.push_back('{26, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01});
    apply_table("clean");
    for (int k = 0; k < NW*NL; k++) begin
      chk($sformatf("clean READ%0d adr/way", k), {28'd0, lg[1+3*k].adr, lg[1+3*k].way},
          {28'd0, 2'(k / NW), 2'(1 << (k % NW))});
    end
    tally(27);
    chk("clean busy cycles", nb, 25);
    chk("clean done pulses", nd, 1);
    chk("clean wbreq cycles", nw, 0);
    chk("clean sel/overlap", sb, 0);
`ifdef CACHE_FLUSH_INVALIDATE_EN
    vmask = 8'h00;
    badcyc = 0;
    for (int n = 0; n <= 27; n++) begin
      if (lg[n].clrv) begin
        vmask[int'(lg[n].adr)*NW + int'(lg[n].way[1])] = 1'b1;
        if ((n % 3) != 0) badcyc++;
      end
    end
    chk("clrv pulses", nv, 8);
    chk("clrv coverage", {24'd0, vmask}, 32'h0000_00FF);
    chk("clrv in advance", badcyc, 0);
`else
    chk("clrv never", nv, 0);
`endif

    // Set 2 way 1 dirty, ack in the fourth WB cycle.
    load(8'h20);
    ack_delay = 3;
    run(32, 99, 0);
    vq.push_back('{17, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'b10});
    vq.push_back('{18, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'b10});
    vq.push_back('{21, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'b10});
    vq.push_back('{22, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'b10});
    vq.push_back('{23, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'b10});
    vq.push_back('{24, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'b01});
    vq.push_back('{29, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'b10});
    vq.push_back('{30, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'b01});
    vq.push_back('{31, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01});
    apply_table("dirty");
    tally(32);
    chk("dirty wbreq cycles", nw, 4);
    chk("dirty clrd cycles", nc, 1);
    chk("dirty busy cycles", nb, 30);
    chk("dirty sel/overlap", sb, 0);
    chk("dirty bits cleared", {24'd0, dirty_mem}, 32'd0);

    // Set 1 way 0 dirty, ack already high on WB entry.
    load(8'h04);
    ack_always = 1'b1;
    run(28, 99, 0);
    ack_always = 1'b0;
    vq.push_back('{8,  1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'b01});
    vq.push_back('{9,  1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'b01});
    vq.push_back('{10, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'b01});
    vq.push_back('{11, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'b01});
    vq.push_back('{12, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'b10});
    vq.push_back('{27, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'b01});
    vq.push_back('{28, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01});
    apply_table("early-ack");
    tally(28);
    chk("early-ack wbreq cycles", nw, 1);
    chk("early-ack clrd cycles", nc, 1);

    // FlushReq raised mid-walk and held through DONE.
    load(8'h00);
    run(52, 10, 26);
    vq.push_back('{13, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'b01});
    vq.push_back('{25, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'b01});
    vq.push_back('{26, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01});
    vq.push_back('{29, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'b10});
    vq.push_back('{50, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'b01});
    vq.push_back('{51, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01});
    apply_table("held-req");
    tally(52);
    chk("held-req done pulses", nd, 2);
    chk("held-req busy cycles", nb, 50);

    // Reset in the middle of a writeback that is never acked.
    load(8'h08);
    ack_delay = 100;
    @(negedge clk); FlushReq = 1'b1;
    @(negedge clk); FlushReq = 1'b0;
    for (int i = 0; i < 40 && !WriteBackReq; i++) @(negedge clk);
    chk("wb entered before reset", {31'd0, WriteBackReq}, 32'd1);
    chk("wb line before reset", {28'd0, FlushAdr, FlushWay}, {28'd0, 2'd1, 2'b10});
    #2 reset = 1'b0;
    #1;
    chk("mid-wb reset ctrl", {26'd0, Busy, FlushDone, WriteBackReq, ClearDirty, ClearValid, FlushAdrSel}, 32'd0);
    chk("mid-wb reset adr/way", {28'd0, FlushAdr, FlushWay}, {28'd0, 2'd0, 2'b01});
    @(negedge clk);
    reset = 1'b1;
    ack_delay = 0;
    run(4, 99, 0);
    vq.push_back('{0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01});
    vq.push_back('{1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01});
    vq.push_back('{4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'b10});
    apply_table("restart");
    for (int i = 0; i < 200 && !FlushDone; i++) @(negedge clk);
    chk("restart done seen", {31'd0, FlushDone}, 32'd1);
    @(negedge clk);
    chk("restart dirty cleared", {24'd0, dirty_mem}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
